// File: rtl/conv3x3_window_ctrl_pkg.sv
// Shared definitions for the 3x3 window pipeline. The window controller,
// window engine and line buffers all use these.
//   CNT_W          : width of the column/row counters and line-buffer address
//   DEF_PIC_*      : default picture geometry
//   DEF_WIDTH      : default pixel word width
//   state_e        : window controller FSM states
package conv_pkg;

  localparam int unsigned CNT_W          = 9;
  localparam int unsigned DEF_PIC_WIDTH  = 480;
  localparam int unsigned DEF_PIC_HEIGHT = 272;
  localparam int unsigned DEF_WIDTH      = 24;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_e;

endpackage

// File: rtl/conv3x3_window_ctrl_if.sv
// Pixel stream, line-buffer strobes and window-engine outputs of the
// 3x3 window controller.
//   slave  : the controller (consumes the stream, drives everything else)
//   master : the stream source / downstream observer
interface conv3x3_window_ctrl_if;

  logic                       pix_valid;
  logic                       pix_sof;
  logic                       lb_wr_en;
  logic                       lb_rd_en;
  logic [conv_pkg::CNT_W-1:0] lb_addr;
  logic                       win_valid;
  logic [conv_pkg::CNT_W-1:0] win_x;
  logic [conv_pkg::CNT_W-1:0] win_y;
  logic                       frame_done;
  logic                       sof_err;
  logic                       busy;

  modport slave (
    input  pix_valid, pix_sof,
    output lb_wr_en, lb_rd_en, lb_addr,
    output win_valid, win_x, win_y,
    output frame_done, sof_err, busy
  );

  modport master (
    output pix_valid, pix_sof,
    input  lb_wr_en, lb_rd_en, lb_addr,
    input  win_valid, win_x, win_y,
    input  frame_done, sof_err, busy
  );

endinterface

// File: rtl/conv3x3_window_ctrl_pix_pos_counter.sv
// Column/row position counter for the pixel stream.
//   clk, rst        : clock, synchronous active-high reset
//   adv_i           : a pixel is accepted this cycle
//   restart_i       : the pixel on the bus is (0,0) of a new frame
//   col_c_o/row_c_o : position of the pixel on the bus (combinational)
//   last_col_c_o    : that pixel is the last of its line
//   last_row_c_o    : that pixel is on the last line of the frame
module pix_pos_counter
  import conv_pkg::*;
#(
  parameter int unsigned PIC_WIDTH  = DEF_PIC_WIDTH,
  parameter int unsigned PIC_HEIGHT = DEF_PIC_HEIGHT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv_i,
  input  logic             restart_i,
  output logic [CNT_W-1:0] col_c_o,
  output logic [CNT_W-1:0] row_c_o,
  output logic             last_col_c_o,
  output logic             last_row_c_o
);

  logic [CNT_W-1:0] col_q, col_d;
  logic [CNT_W-1:0] row_q, row_d;

  // An SOF pixel is (0,0) regardless of where the previous frame stopped
  assign col_c_o      = restart_i ? '0 : col_q;
  assign row_c_o      = restart_i ? '0 : row_q;
  assign last_col_c_o = (col_c_o == CNT_W'(PIC_WIDTH - 1));
  assign last_row_c_o = (row_c_o == CNT_W'(PIC_HEIGHT - 1));

  // Next position; wrapping past the last pixel returns to (0,0)
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (adv_i) begin
      if (last_col_c_o) begin
        col_d = '0;
        row_d = last_row_c_o ? '0 : row_c_o + CNT_W'(1);
      end else begin
        col_d = col_c_o + CNT_W'(1);
        row_d = row_c_o;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

endmodule

// File: rtl/conv3x3_window_ctrl.sv
// Sequencer for the 3x3 window/gradient datapath: tracks pixel position,
// strobes the line buffers, qualifies full 3x3 windows and reports frame
// completion or SOF aborts.
//   clk, rst : clock, synchronous active-high reset
//   bus      : pixel stream in; line-buffer strobes (combinational),
//              win_valid/win_x/win_y, frame_done, sof_err (registered),
//              busy (decoded from the state register)
module conv3x3_window_ctrl
  import conv_pkg::*;
#(
  parameter int unsigned PIC_WIDTH  = DEF_PIC_WIDTH,
  parameter int unsigned PIC_HEIGHT = DEF_PIC_HEIGHT,
  parameter int unsigned WIDTH      = DEF_WIDTH
) (
  input logic                  clk,
  input logic                  rst,
  conv3x3_window_ctrl_if.slave bus
);

  if (PIC_WIDTH < 3 || PIC_WIDTH > 511 || PIC_HEIGHT < 3 || PIC_HEIGHT > 511 || WIDTH < 1)
  begin : g_bad_param
    $error("conv3x3_window_ctrl: picture size or pixel width out of range");
  end

  state_e           state_q, state_d;
  logic             win_valid_q, win_valid_d;
  logic [CNT_W-1:0] win_x_q, win_x_d;
  logic [CNT_W-1:0] win_y_q, win_y_d;
  logic             frame_done_q, frame_done_d;
  logic             sof_err_q, sof_err_d;

  logic             accept;
  logic             sof_hit;
  logic [CNT_W-1:0] col, row;
  logic             last_col, last_row;

  // In IDLE only an SOF pixel starts a frame; elsewhere every valid pixel counts
  assign accept  = bus.pix_valid & ((state_q != IDLE) | bus.pix_sof);
  assign sof_hit = accept & bus.pix_sof;

  pix_pos_counter #(
    .PIC_WIDTH  (PIC_WIDTH),
    .PIC_HEIGHT (PIC_HEIGHT)
  ) u_pos (
    .clk          (clk),
    .rst          (rst),
    .adv_i        (accept),
    .restart_i    (sof_hit),
    .col_c_o      (col),
    .row_c_o      (row),
    .last_col_c_o (last_col),
    .last_row_c_o (last_row)
  );

  // Read-before-write line buffers: read and write the same column together
  assign bus.lb_wr_en   = accept;
  assign bus.lb_rd_en   = accept;
  assign bus.lb_addr    = col;
  assign bus.busy       = (state_q != IDLE);
  assign bus.win_valid  = win_valid_q;
  assign bus.win_x      = win_x_q;
  assign bus.win_y      = win_y_q;
  assign bus.frame_done = frame_done_q;
  assign bus.sof_err    = sof_err_q;

  // Next-state and registered-output decode; SOF beats end-of-frame
  always_comb begin
    state_d      = state_q;
    win_valid_d  = 1'b0;
    win_x_d      = win_x_q;
    win_y_d      = win_y_q;
    frame_done_d = 1'b0;
    sof_err_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = FILL;
      end
      FILL: begin
        if (accept) begin
          if (bus.pix_sof) begin
            sof_err_d = 1'b1;
          end else if (last_col && row == CNT_W'(1)) begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (accept) begin
          if (bus.pix_sof) begin
            state_d   = FILL;
            sof_err_d = 1'b1;
          end else begin
            // Window centre trails the incoming pixel by one row and column
            if (col >= CNT_W'(2)) begin
              win_valid_d = 1'b1;
              win_x_d     = col - CNT_W'(1);
              win_y_d     = row - CNT_W'(1);
            end
            if (last_col && last_row) begin
              state_d      = IDLE;
              frame_done_d = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      win_valid_q  <= 1'b0;
      win_x_q      <= '0;
      win_y_q      <= '0;
      frame_done_q <= 1'b0;
      sof_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      win_valid_q  <= win_valid_d;
      win_x_q      <= win_x_d;
      win_y_q      <= win_y_d;
      frame_done_q <= frame_done_d;
      sof_err_q    <= sof_err_d;
    end
  end

endmodule

// File: tb/tb_conv3x3_window_ctrl.sv
// Directed bench for conv3x3_window_ctrl on an 8x4 picture.
module tb_conv3x3_window_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  conv3x3_window_ctrl_if bus ();

  conv3x3_window_ctrl #(
    .PIC_WIDTH  (8),
    .PIC_HEIGHT (4),
    .WIDTH      (24)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Observer: logs strobes and pulses on the falling edge
  int         cyc = 0;
  int         busy_hi = 0;
  int         bad_wr = 0;
  int         wr_cyc[$];
  logic [8:0] addr_q[$];
  logic [8:0] wx_q[$];
  logic [8:0] wy_q[$];
  int         done_cyc[$];
  int         err_cyc[$];

  always @(negedge clk) begin
    cyc++;
    if (bus.lb_wr_en) begin
      wr_cyc.push_back(cyc);
      addr_q.push_back(bus.lb_addr);
      if (!bus.pix_valid) bad_wr++;
    end
    if (bus.lb_rd_en !== bus.lb_wr_en) bad_wr++;
    if (bus.win_valid) begin
      wx_q.push_back(bus.win_x);
      wy_q.push_back(bus.win_y);
    end
    if (bus.frame_done) done_cyc.push_back(cyc);
    if (bus.sof_err) err_cyc.push_back(cyc);
    if (bus.busy) busy_hi++;
  end

  task automatic clear_mon();
    busy_hi = 0;
    bad_wr  = 0;
    wr_cyc.delete();
    addr_q.delete();
    wx_q.delete();
    wy_q.delete();
    done_cyc.delete();
    err_cyc.delete();
  endtask

  task automatic drive(input logic v, input logic s);
    @(posedge clk);
    #1;
    bus.pix_valid = v;
    bus.pix_sof   = s;
  endtask

  task automatic send_frame(input bit gaps);
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, i == 0);
      if (gaps) drive(1'b0, 1'b0);
    end
  endtask

  task automatic flush(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0);
  endtask

  task automatic test_reset();
    bus.pix_valid = 1'b0;
    bus.pix_sof   = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({bus.win_valid, bus.win_x, bus.win_y, bus.frame_done, bus.sof_err, bus.busy,
         bus.lb_wr_en, bus.lb_rd_en, bus.lb_addr} !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got wv=%b x=%0d y=%0d fd=%b se=%b busy=%b wr=%b rd=%b addr=%0d, want all 0",
               bus.win_valid, bus.win_x, bus.win_y, bus.frame_done, bus.sof_err, bus.busy,
               bus.lb_wr_en, bus.lb_rd_en, bus.lb_addr);
    end
  endtask

  task automatic test_frame(input bit gaps);
    clear_mon();
    send_frame(gaps);
    flush(3);
    vectors++;
    if (wr_cyc.size() != 32) begin
      miscompares++;
      $display("FAIL frame_wr_count(gaps=%0d): got %0d want 32", gaps, wr_cyc.size());
    end
    for (int i = 0; i < 32; i++) begin
      vectors++;
      if (i >= addr_q.size() || addr_q[i] !== 9'(i % 8)) begin
        miscompares++;
        $display("FAIL frame_addr%0d(gaps=%0d): got %0d want %0d", i, gaps,
                 (i < addr_q.size()) ? addr_q[i] : 9'h1ff, i % 8);
      end
    end
    vectors++;
    if (bad_wr != 0) begin
      miscompares++;
      $display("FAIL frame_strobes(gaps=%0d): got %0d bad strobes want 0", gaps, bad_wr);
    end
    vectors++;
    if (wx_q.size() != 12) begin
      miscompares++;
      $display("FAIL frame_win_count(gaps=%0d): got %0d want 12", gaps, wx_q.size());
    end
    for (int k = 0; k < 12; k++) begin
      vectors++;
      if (k >= wx_q.size() || wx_q[k] !== 9'(1 + k % 6) || wy_q[k] !== 9'(1 + k / 6)) begin
        miscompares++;
        $display("FAIL frame_win%0d(gaps=%0d): got (%0d,%0d) want (%0d,%0d)", k, gaps,
                 (k < wx_q.size()) ? wx_q[k] : 9'h1ff, (k < wy_q.size()) ? wy_q[k] : 9'h1ff,
                 1 + k % 6, 1 + k / 6);
      end
    end
    vectors++;
    if (done_cyc.size() != 1 || wr_cyc.size() != 32 || done_cyc[0] != wr_cyc[31] + 1) begin
      miscompares++;
      $display("FAIL frame_done(gaps=%0d): got %0d pulses want 1 one cycle after last pixel",
               gaps, done_cyc.size());
    end
    vectors++;
    if (err_cyc.size() != 0) begin
      miscompares++;
      $display("FAIL frame_sof_err(gaps=%0d): got %0d want 0", gaps, err_cyc.size());
    end
  endtask

  task automatic test_idle_drop();
    clear_mon();
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0);
    flush(2);
    vectors++;
    if (wr_cyc.size() != 0 || busy_hi != 0) begin
      miscompares++;
      $display("FAIL idle_drop: got wr=%0d busy_cycles=%0d want 0/0", wr_cyc.size(), busy_hi);
    end
    test_frame(1'b0);
  endtask

  task automatic test_sof_abort();
    clear_mon();
    for (int i = 0; i < 19; i++) drive(1'b1, i == 0);
    drive(1'b1, 1'b1);
    for (int i = 1; i < 32; i++) drive(1'b1, 1'b0);
    flush(3);
    vectors++;
    if (wr_cyc.size() != 51) begin
      miscompares++;
      $display("FAIL abort_wr_count: got %0d want 51", wr_cyc.size());
    end
    vectors++;
    if (err_cyc.size() != 1 || wr_cyc.size() < 20 || err_cyc[0] != wr_cyc[19] + 1) begin
      miscompares++;
      $display("FAIL abort_sof_err: got %0d pulses want 1 right after the SOF pixel", err_cyc.size());
    end
    vectors++;
    if (addr_q.size() < 21 || addr_q[19] !== 9'd0 || addr_q[20] !== 9'd1) begin
      miscompares++;
      $display("FAIL abort_addr: got %0d,%0d want 0,1",
               (addr_q.size() > 19) ? addr_q[19] : 9'h1ff, (addr_q.size() > 20) ? addr_q[20] : 9'h1ff);
    end
    vectors++;
    if (done_cyc.size() != 1 || wr_cyc.size() != 51 || done_cyc[0] != wr_cyc[50] + 1) begin
      miscompares++;
      $display("FAIL abort_frame_done: got %0d pulses want 1 after the new frame", done_cyc.size());
    end
    vectors++;
    if (wx_q.size() != 13 || wx_q[0] !== 9'd1 || wy_q[0] !== 9'd1) begin
      miscompares++;
      $display("FAIL abort_win_count: got %0d windows want 13 starting at (1,1)", wx_q.size());
    end
    for (int k = 0; k < 12; k++) begin
      vectors++;
      if (k + 1 >= wx_q.size() || wx_q[k+1] !== 9'(1 + k % 6) || wy_q[k+1] !== 9'(1 + k / 6)) begin
        miscompares++;
        $display("FAIL abort_win%0d: got (%0d,%0d) want (%0d,%0d)", k,
                 (k + 1 < wx_q.size()) ? wx_q[k+1] : 9'h1ff, (k + 1 < wy_q.size()) ? wy_q[k+1] : 9'h1ff,
                 1 + k % 6, 1 + k / 6);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    clear_mon();
    for (int i = 0; i < 21; i++) drive(1'b1, i == 0);
    drive(1'b1, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.pix_valid = 1'b0;
    bus.pix_sof   = 1'b0;
    @(negedge clk);
    vectors++;
    if ({bus.win_valid, bus.win_x, bus.win_y, bus.frame_done, bus.sof_err, bus.busy,
         bus.lb_wr_en, bus.lb_rd_en, bus.lb_addr} !== 32'd0) begin
      miscompares++;
      $display("FAIL mid_reset_outputs: got wv=%b x=%0d y=%0d fd=%b se=%b busy=%b wr=%b addr=%0d, want all 0",
               bus.win_valid, bus.win_x, bus.win_y, bus.frame_done, bus.sof_err, bus.busy,
               bus.lb_wr_en, bus.lb_addr);
    end
    test_frame(1'b0);
  endtask

  task automatic test_back_to_back();
    clear_mon();
    send_frame(1'b0);
    send_frame(1'b0);
    flush(3);
    vectors++;
    if (wr_cyc.size() != 64) begin
      miscompares++;
      $display("FAIL b2b_wr_count: got %0d want 64", wr_cyc.size());
    end
    vectors++;
    if (done_cyc.size() != 2 || wr_cyc.size() != 64 ||
        done_cyc[0] != wr_cyc[32] || done_cyc[1] != wr_cyc[63] + 1) begin
      miscompares++;
      $display("FAIL b2b_frame_done: got %0d pulses want 2 (first alongside next SOF)", done_cyc.size());
    end
    vectors++;
    if (err_cyc.size() != 0) begin
      miscompares++;
      $display("FAIL b2b_sof_err: got %0d want 0", err_cyc.size());
    end
    vectors++;
    if (wx_q.size() != 24) begin
      miscompares++;
      $display("FAIL b2b_win_count: got %0d want 24", wx_q.size());
    end
    for (int k = 0; k < 24; k++) begin
      vectors++;
      if (k >= wx_q.size() || wx_q[k] !== 9'(1 + (k % 12) % 6) || wy_q[k] !== 9'(1 + (k % 12) / 6)) begin
        miscompares++;
        $display("FAIL b2b_win%0d: got (%0d,%0d) want (%0d,%0d)", k,
                 (k < wx_q.size()) ? wx_q[k] : 9'h1ff, (k < wy_q.size()) ? wy_q[k] : 9'h1ff,
                 1 + (k % 12) % 6, 1 + (k % 12) / 6);
      end
    end
  endtask

  initial begin
    test_reset();
    test_frame(1'b0);
    test_frame(1'b1);
    test_idle_drop();
    test_sof_abort();
    test_reset_mid_frame();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
